// File: rtl/convolve_mul_arb_pkg.sv
// rtl/convolve_mul_arb_pkg.sv - shared widths, id helper and tag type for the multiplier arbiter
package convolve_mul_arb_pkg;

    localparam int A_W_DEF = 16;
    localparam int B_W_DEF = 8;
    localparam int P_W_DEF = 16;
    localparam int MAX_REQ = 8;

    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Tag ids are sized for the largest supported requester count.
    localparam int TAG_ID_W = id_w(MAX_REQ);

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/convolve_rr_arbiter.sv
// rtl/convolve_rr_arbiter.sv - round-robin grant, pointer advances only when the grant is issued
module convolve_rr_arbiter
    import convolve_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic                issue_en,
    output logic                issue,
    output logic [TAG_ID_W-1:0] grant_id,
    output logic [NUM_REQ-1:0]  grant
);

    localparam logic [TAG_ID_W+1:0] NREQ = (TAG_ID_W+2)'(NUM_REQ);
    localparam logic [TAG_ID_W+1:0] ONE  = (TAG_ID_W+2)'(1);

    logic [TAG_ID_W-1:0] last_q, last_d;
    logic [TAG_ID_W+1:0] start;
    logic [TAG_ID_W+1:0] pos;
    logic [NUM_REQ-1:0]  rot;
    logic                found;

    always_comb begin
        start = {2'b00, last_q} + ONE;
        if (start >= NREQ) begin
            start = '0;
        end
        // Duplicated vector lets a plain shift implement the wrap-around search.
        rot   = NUM_REQ'({req_valid, req_valid} >> start);
        found = 1'b0;
        pos   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                pos   = start + (TAG_ID_W+2)'(j);
            end
        end
        if (pos >= NREQ) begin
            pos = pos - NREQ;
        end
        grant_id = pos[TAG_ID_W-1:0];
        issue    = found && issue_en;
        grant    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = issue && (grant_id == TAG_ID_W'(i));
        end
        last_d = issue ? grant_id : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= TAG_ID_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/convolve_mul_arbiter.sv
// rtl/convolve_mul_arbiter.sv - shares one pipelined multiplier among requesters; MUL_ARB_STATS_EN adds counters
module convolve_mul_arbiter
    import convolve_mul_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3,
    parameter int A_W         = A_W_DEF,
    parameter int B_W         = B_W_DEF,
    parameter int P_W         = P_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [NUM_REQ-1:0]     res_valid,
    input  logic [NUM_REQ-1:0]     res_ready,
    output logic [P_W-1:0]         res_p,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout,
    output logic [31:0]            stat_issue_cnt,
    output logic [31:0]            stat_stall_cnt
);

    mul_tag_t            tag_q [MUL_LATENCY];
    mul_tag_t            tag_d [MUL_LATENCY];
    mul_tag_t            tail;
    logic                blocked;
    logic                issue_en;
    logic                issue;
    logic [TAG_ID_W-1:0] grant_id;
    logic [NUM_REQ-1:0]  grant;

    // A result that its owner will not take freezes every multiplier stage.
    always_comb begin
        tail      = tag_q[MUL_LATENCY-1];
        blocked   = 1'b0;
        res_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tail.vld && (tail.id == TAG_ID_W'(i))) begin
                res_valid[i] = !reset;
                if (!res_ready[i]) begin
                    blocked = 1'b1;
                end
            end
        end
        mul_ce   = reset || !blocked;
        issue_en = mul_ce && !reset;
    end

    assign res_p     = mul_dout;
    assign req_ready = grant;

    convolve_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .issue_en  (issue_en),
        .issue     (issue),
        .grant_id  (grant_id),
        .grant     (grant)
    );

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_din0 = req_a[i*A_W +: A_W];
                mul_din1 = req_b[i*B_W +: B_W];
            end
        end
    end

    always_comb begin
        tag_d = tag_q;
        if (mul_ce) begin
            for (int k = MUL_LATENCY - 1; k > 0; k--) begin
                tag_d[k] = tag_q[k-1];
            end
            tag_d[0].vld = issue;
            tag_d[0].id  = grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MUL_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

`ifdef MUL_ARB_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q + {31'b0, issue};
        stall_cnt_d = stall_cnt_q + {31'b0, !mul_ce};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_issue_cnt = issue_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`else
    assign stat_issue_cnt = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: doc/convolve_mul_arbiter.md
# convolve_mul_arbiter

Shares one pipelined 16-bit signed × 8-bit unsigned convolution multiplier among NUM_REQ requesters using valid/ready handshakes. A round-robin arbiter selects one request per cycle and drives the multiplier operands and clock-enable. A tag pipeline tracks each in-flight product and returns it to the requester that issued it. The block sits between the convolution tap engines and the shared DSP multiplier instance. It owns the multiplier `ce` and stalls the whole multiplier when a result cannot be delivered.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- MUL_LATENCY, 3: ce-qualified register stages from multiplier din to dout
- A_W, 16: signed operand width
- B_W, 8: unsigned operand width
- P_W, 16: product width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_a  in  NUM_REQ*A_W  packed signed operands; requester i at [i*A_W +: A_W]
- req_b  in  NUM_REQ*B_W  packed unsigned operands
- res_valid  out  NUM_REQ  one-hot result valid
- res_ready  in  NUM_REQ  per-requester result accept
- res_p  out  P_W  shared result bus; qualified by res_valid
- mul_ce  out  1  multiplier clock-enable
- mul_din0  out  A_W  multiplier operand a
- mul_din1  out  B_W  multiplier operand b
- mul_dout  in  P_W  multiplier product
- stat_issue_cnt  out  32  issued operations
- stat_stall_cnt  out  32  cycles with mul_ce low

## Operation
- Tag pipeline: MUL_LATENCY entries of {vld, id}. It shifts only when mul_ce=1. Entry 0 loads {issue, grant_id}.
- Stall rule: mul_ce = !(tail.vld && !res_ready[tail.id]). It is combinational.
- Result delivery:
  - res_valid[i] = tail.vld && tail.id==i.
  - res_p = mul_dout unmodified: low 16 bits of a × {0,b}, no saturation.
- Arbitration:
  - Round-robin pointer `last`. Candidates are searched from last+1 upward with wrap, and the first req_valid wins.
  - `issue` = any req_valid && mul_ce.
  - req_ready[g] = issue for the granted g only.
  - `last` is updated to g only on issue.
- Operand drive:
  - mul_din0/mul_din1 carry the granted requester's slices.
  - When there is no grant, both are driven 0 and a bubble (vld=0) enters the tag pipeline.
- Requester contract: a requester holds req_a/req_b stable while req_valid is high and not yet accepted. The block does not check this.
- Simultaneous stall and request: no issue, req_ready all 0, pointer unchanged.
- Result handshake to requester i takes place on cycle-level res_valid[i] && res_ready[i]. The pipeline advances on that same edge.

## Timing
- Reset values:
  - Tag pipeline vld all 0.
  - last = NUM_REQ-1, so requester 0 has first priority.
  - Counters 0.
  - During reset: req_ready=0, res_valid=0, mul_ce=1, mul_din*=0.
- Latency: a request accepted in cycle T (no stalls) presents its result in cycle T+MUL_LATENCY. Each stall cycle adds one cycle.
- Throughput: one issue per cycle while mul_ce=1.
- Stall: all multiplier stages freeze together, and mul_dout holds its value. No product is lost or duplicated.
- Reset during operation: in-flight products are discarded and never signalled. The first post-reset grant goes to requester 0.

## Configuration
- MUL_ARB_STATS_EN defined:
  - stat_issue_cnt increments on each issue.
  - stat_stall_cnt increments on each cycle with mul_ce=0.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- MUL_ARB_STATS_EN undefined: no counter logic is built, and both ports are tied to 0.

## Structure
- Package convolve_mul_arb_pkg holds:
  - A_W, B_W and P_W defaults
  - ID_W = $clog2(NUM_REQ) helper
  - typedef mul_tag_t {vld, id}
- Sub-module convolve_rr_arbiter: parameterised NUM_REQ round-robin grant with the update-on-issue pointer. It is reusable for other shared datapath resources.

## Test plan
- Single requester: req0 a=-3, b=200, held valid one cycle → req_ready[0] in cycle 0, res_valid[0] with res_p=0xFDA8 (-600) in cycle 3.
- All four requesters continuously valid, res_ready all 1 → grants 0,1,2,3,0,… one per cycle; results return in the same order 3 cycles later; stat_issue_cnt=8 after 8 issues.
- Backpressure: req1 a=100, b=2 issued, res_ready[1]=0 for 5 cycles → mul_ce low for 5 cycles, res_p held at 200, req_ready all 0, stat_stall_cnt=5; result delivered when res_ready[1] rises.
- Boundary operands: a=-32768, b=255 → res_p=0x8000 (low 16 bits of -8355840); a=32767, b=0 → res_p=0.
- Reset mid-flight: issue 3 operations, assert reset for 1 cycle → no res_valid afterward for those operations; next grant goes to requester 0 with latency 3.
- Idle bubbles: requests on alternate cycles → mul_din0/mul_din1=0 in the gaps; results are spaced 2 cycles apart with no spurious res_valid.
